// File: rtl/gpu_run_ctrl_pkg.sv
// Shared definitions for the GPU run controller: register map, CTRL/STATUS
// bit positions and the run-sequencer state encoding.
package gpu_run_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
    localparam logic [1:0] ADDR_FRAMES  = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_PENDING = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } run_state_t;

endpackage

// File: rtl/gpu_run_ctrl.sv
// Avalon-MM controlled GPU run sequencer: starts/aborts GPU runs, enforces an
// optional run timeout, queues one pending start and counts completed frames.
module gpu_run_ctrl
    import gpu_run_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        gpu_done,
    output logic        gpu_run,
    output logic        irq
);

    run_state_t             r_state;
    run_state_t             w_state_nxt;
    logic                   r_gpu_run;
    logic                   r_irq_en;
    logic                   r_done;
    logic                   r_tmo_flag;
    logic                   r_pending;
    logic [TIMEOUT_W-1:0]   r_timeout;
    logic [TIMEOUT_W-1:0]   r_run_cnt;
    logic [31:0]            r_frames;

    logic w_wr, w_ctrl_wr, w_stat_wr, w_tmo_wr, w_frames_wr;
    logic w_start, w_abort, w_tmo_hit;
    logic w_done_evt, w_tmo_evt, w_pend_nxt, w_cnt_load;
    logic w_unused_wdata;

    assign w_wr        = chipselect & ~write_n;
    assign w_ctrl_wr   = w_wr & (address == ADDR_CTRL);
    assign w_stat_wr   = w_wr & (address == ADDR_STATUS);
    assign w_tmo_wr    = w_wr & (address == ADDR_TIMEOUT);
    assign w_frames_wr = w_wr & (address == ADDR_FRAMES);
    assign w_unused_wdata = ^writedata;

    // ABORT dominates START when both arrive in one write
    assign w_abort   = w_ctrl_wr & writedata[CTRL_ABORT];
    assign w_start   = w_ctrl_wr & writedata[CTRL_START] & ~writedata[CTRL_ABORT];
    assign w_tmo_hit = (r_timeout != '0) && (r_run_cnt == r_timeout - TIMEOUT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_done_evt  = 1'b0;
        w_tmo_evt   = 1'b0;
        w_pend_nxt  = r_pending;
        w_cnt_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_abort) begin
                    w_pend_nxt = 1'b0;
                end else if (w_start) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_load  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_nxt = ST_GAP;
                    w_pend_nxt  = 1'b0;
                end else begin
                    if (w_start) w_pend_nxt = 1'b1;
                    // a completion coinciding with the timeout counts as completion
                    if (gpu_done) begin
                        w_state_nxt = ST_GAP;
                        w_done_evt  = 1'b1;
                    end else if (w_tmo_hit) begin
                        w_state_nxt = ST_GAP;
                        w_tmo_evt   = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
                if (w_abort) begin
                    w_pend_nxt = 1'b0;
                end else if (r_pending | w_start) begin
                    w_state_nxt = ST_RUN;
                    w_pend_nxt  = 1'b0;
                    w_cnt_load  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_gpu_run  <= 1'b0;
            r_irq_en   <= 1'b0;
            r_done     <= 1'b0;
            r_tmo_flag <= 1'b0;
            r_pending  <= 1'b0;
            r_timeout  <= '0;
            r_run_cnt  <= '0;
            r_frames   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gpu_run  <= (w_state_nxt == ST_RUN);
            r_pending  <= w_pend_nxt;
            if (w_ctrl_wr) r_irq_en <= writedata[CTRL_IRQ_EN];
            if (w_tmo_wr)  r_timeout <= writedata[TIMEOUT_W-1:0];
            // set events win over a coincident write-1-to-clear
            r_done     <= w_done_evt | (r_done & ~(w_stat_wr & writedata[STAT_DONE]));
            r_tmo_flag <= w_tmo_evt | (r_tmo_flag & ~(w_stat_wr & writedata[STAT_TIMEOUT]));
            if (w_cnt_load)
                r_run_cnt <= '0;
            else if (r_state == ST_RUN)
                r_run_cnt <= r_run_cnt + TIMEOUT_W'(1);
            if (w_frames_wr)
                r_frames <= '0;
            else if (w_done_evt)
                r_frames <= r_frames + 32'd1;
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                ADDR_CTRL:    readdata[CTRL_IRQ_EN] = r_irq_en;
                ADDR_STATUS: begin
                    readdata[STAT_BUSY]    = (r_state != ST_IDLE);
                    readdata[STAT_DONE]    = r_done;
                    readdata[STAT_TIMEOUT] = r_tmo_flag;
                    readdata[STAT_PENDING] = r_pending;
                end
                ADDR_TIMEOUT: readdata = 32'(r_timeout);
                default:      readdata = r_frames;
            endcase
        end
    end

    assign gpu_run = r_gpu_run;
    assign irq     = r_irq_en & (r_done | r_tmo_flag);

endmodule

// File: tb/tb_gpu_run_ctrl.sv
// Self-checking bench for gpu_run_ctrl: a cycle-level behavioural model
// checked every cycle, plus directed register reads with literal expectations.
module tb_gpu_run_ctrl;

    localparam int TW = 24;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        gpu_done = 1'b0;
    logic        gpu_run;
    logic        irq;

    always #5 clk = ~clk;

    gpu_run_ctrl #(.TIMEOUT_W(TW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .gpu_done   (gpu_done),
        .gpu_run    (gpu_run),
        .irq        (irq)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: a run is "active" for as many cycles as it lasts,
    // followed by one idle gap cycle; at most one start is remembered.
    bit          m_running, m_gap, m_queued, m_irq_en, m_done, m_tflag;
    int          m_elapsed, m_tmo;
    logic [31:0] m_frames;
    int          preload_seq = 0, seen_seq = 0;
    bit          e_wr, e_start, e_abort, e_fin_done, e_fin_to;
    bit          n_running, n_gap, n_queued, n_done, n_tflag;
    int          n_el;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, m_irq_en, 2'b00};
            2'd1:    return {28'd0, m_queued, m_tflag, m_done, (m_running | m_gap)};
            2'd2:    return 32'(m_tmo);
            default: return m_frames;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_running = 0; m_gap = 0; m_queued = 0; m_irq_en = 0;
            m_done = 0; m_tflag = 0; m_elapsed = 0; m_tmo = 0; m_frames = 32'd0;
        end else begin
            if (preload_seq != seen_seq) begin
                m_frames = 32'hFFFF_FFFF;
                seen_seq = preload_seq;
            end
            e_wr    = chipselect & ~write_n;
            e_abort = e_wr && address == 2'd0 && writedata[1];
            e_start = e_wr && address == 2'd0 && writedata[0] && !writedata[1];
            e_fin_done = 0; e_fin_to = 0;
            n_running = m_running; n_gap = 0; n_queued = m_queued; n_el = m_elapsed;
            if (m_running) begin
                n_el = m_elapsed + 1;
                if (e_abort) begin
                    n_running = 0; n_gap = 1; n_queued = 0;
                end else begin
                    if (e_start) n_queued = 1;
                    if (gpu_done) begin
                        e_fin_done = 1; n_running = 0; n_gap = 1;
                    end else if (m_tmo != 0 && n_el == m_tmo) begin
                        e_fin_to = 1; n_running = 0; n_gap = 1;
                    end
                end
            end else if (m_gap) begin
                if (e_abort) n_queued = 0;
                else if (m_queued || e_start) begin
                    n_running = 1; n_el = 0; n_queued = 0;
                end
            end else begin
                if (e_abort) n_queued = 0;
                else if (e_start) begin
                    n_running = 1; n_el = 0;
                end
            end
            n_done = m_done; n_tflag = m_tflag;
            if (e_wr && address == 2'd1) begin
                if (writedata[1]) n_done = 0;
                if (writedata[2]) n_tflag = 0;
            end
            if (e_fin_done) n_done = 1;
            if (e_fin_to) n_tflag = 1;
            if (e_wr && address == 2'd0) m_irq_en = writedata[2];
            if (e_wr && address == 2'd2) m_tmo = int'(writedata[TW-1:0]);
            if (e_wr && address == 2'd3) m_frames = 32'd0;
            else if (e_fin_done) m_frames = m_frames + 32'd1;
            m_running = n_running; m_gap = n_gap; m_queued = n_queued;
            m_elapsed = n_el; m_done = n_done; m_tflag = n_tflag;
        end
    end

    int hi_len = 0, lo_len = 0, last_hi = 0, last_lo = 0, n_runs = 0;

    always @(negedge clk) begin
        chk("gpu_run", 32'(gpu_run), 32'(m_running));
        chk("irq", 32'(irq), 32'(m_irq_en & (m_done | m_tflag)));
        if (gpu_run) begin
            if (lo_len != 0) last_lo = lo_len;
            lo_len = 0;
            hi_len++;
        end else begin
            if (hi_len != 0) begin
                last_hi = hi_len;
                n_runs++;
            end
            hi_len = 0;
            lo_len++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] lit);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        chk(name, readdata, m_read(a));
        chk({name, "_lit"}, readdata, lit);
        chipselect = 1'b0;
    endtask

    task automatic pulse();
        gpu_done = 1'b1;
        tick(1);
        gpu_done = 1'b0;
    endtask

    int runs_before;

    initial begin
        tick(3);
        rd("rst_ctrl", 2'd0, 32'h0);
        rd("rst_status", 2'd1, 32'h0);
        rd("rst_timeout", 2'd2, 32'h0);
        rd("rst_frames", 2'd3, 32'h0);
        reset_n = 1'b1;
        tick(2);

        // basic run ended by gpu_done
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h1);
        tick(9);
        pulse();
        tick(2);
        chk("run_len_10", 32'(last_hi), 32'd10);
        rd("t1_status", 2'd1, 32'h2);
        rd("t1_frames", 2'd3, 32'd1);
        chk("t1_irq", 32'(irq), 32'd0);

        // timeout with interrupt
        wr(2'd1, 32'h2);
        wr(2'd2, 32'd5);
        wr(2'd0, 32'h5);
        tick(7);
        chk("run_len_5", 32'(last_hi), 32'd5);
        rd("t2_status", 2'd1, 32'h4);
        rd("t2_ctrl", 2'd0, 32'h4);
        rd("t2_tmo", 2'd2, 32'd5);
        chk("t2_irq_on", 32'(irq), 32'd1);
        wr(2'd1, 32'h4);
        chk("t2_irq_off", 32'(irq), 32'd0);
        rd("t2_status_clr", 2'd1, 32'h0);

        // queued start, duplicate dropped
        wr(2'd2, 32'd0);
        wr(2'd3, 32'h1234);
        runs_before = n_runs;
        wr(2'd0, 32'h5);
        wr(2'd0, 32'h5);
        wr(2'd0, 32'h5);
        rd("t3_pending", 2'd1, 32'h9);
        pulse();
        tick(3);
        rd("t3_second_run", 2'd1, 32'h3);
        chk("t3_gap_len", 32'(last_lo), 32'd1);
        pulse();
        tick(3);
        rd("t3_frames", 2'd3, 32'd2);
        chk("t3_runs", 32'(n_runs - runs_before), 32'd2);

        // start+abort together, abort with pending
        wr(2'd1, 32'h6);
        wr(2'd0, 32'h3);
        tick(1);
        rd("t4_idle", 2'd1, 32'h0);
        chk("t4_run_low", 32'(gpu_run), 32'd0);
        wr(2'd0, 32'h1);
        wr(2'd0, 32'h1);
        rd("t4_pend", 2'd1, 32'h9);
        wr(2'd0, 32'h2);
        tick(2);
        rd("t4_after_abort", 2'd1, 32'h0);
        rd("t4_frames", 2'd3, 32'd2);

        // gpu_done outside a run is ignored
        pulse();
        tick(1);
        rd("t5_stray_done", 2'd3, 32'd2);

        // frames wrap from all-ones
        force dut.r_frames = 32'hFFFF_FFFF;
        #1;
        release dut.r_frames;
        preload_seq++;
        wr(2'd0, 32'h1);
        tick(2);
        pulse();
        tick(2);
        rd("t5_wrap", 2'd3, 32'd0);
        wr(2'd0, 32'h1);
        tick(2);
        pulse();
        tick(2);
        rd("t5_after_wrap", 2'd3, 32'd1);

        // frames clear coincident with completion
        wr(2'd0, 32'h1);
        tick(2);
        address = 2'd3; chipselect = 1'b1; write_n = 1'b0; gpu_done = 1'b1;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1; gpu_done = 1'b0;
        tick(2);
        rd("t5_clr_vs_inc", 2'd3, 32'd0);
        rd("t5_done_set", 2'd1, 32'h2);

        // status clear coincident with completion
        wr(2'd1, 32'h6);
        wr(2'd0, 32'h1);
        tick(2);
        address = 2'd1; writedata = 32'h2; chipselect = 1'b1; write_n = 1'b0; gpu_done = 1'b1;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0; gpu_done = 1'b0;
        tick(2);
        rd("t6_set_wins", 2'd1, 32'h2);

        // completion on the timeout cycle
        wr(2'd1, 32'h6);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h1);
        tick(2);
        pulse();
        tick(2);
        chk("t7_run_len", 32'(last_hi), 32'd3);
        rd("t7_status", 2'd1, 32'h2);
        rd("t7_frames", 2'd3, 32'd2);

        // asynchronous reset in the middle of a run
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h5);
        tick(3);
        chk("t8_running", 32'(gpu_run), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t8_async_drop", 32'(gpu_run), 32'd0);
        tick(2);
        pulse();
        reset_n = 1'b1;
        tick(1);
        pulse();
        tick(2);
        rd("t8_ctrl", 2'd0, 32'h0);
        rd("t8_status", 2'd1, 32'h0);
        rd("t8_timeout", 2'd2, 32'h0);
        rd("t8_frames", 2'd3, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
